// File: rtl/fmul32_pkg.sv
// Shared constants, FSM state and flag types for the FMUL32 back end.
package fmul32_pkg;

    localparam int unsigned EXP_W    = 8;
    localparam int unsigned MAN_W    = 24;
    localparam int unsigned DATA_W   = 1 + EXP_W + MAN_W - 1;
    localparam int unsigned FRAC_W   = MAN_W - 1;
    localparam int unsigned PROD_W   = 2 * MAN_W;
    localparam int unsigned CNT_W    = $clog2(MAN_W);
    localparam int unsigned EXP_BIAS = 127;
    localparam int unsigned EXP_MAX  = 2 * EXP_BIAS + 1;

    localparam logic [DATA_W-1:0] QNAN = 32'h7FC0_0000;

    typedef enum logic [1:0] {
        IDLE,
        MUL,
        NORM,
        DONE
    } state_t;

    typedef struct packed {
        logic overflow;
        logic underflow;
        logic inexact;
    } flags_t;

endpackage

// File: rtl/fmul32_round_pack.sv
// Normalize, round-to-nearest-even and pack a 48-bit mantissa product.
// FMUL32_BE_FLAGS_EN adds the {overflow, underflow, inexact} output.
module fmul32_round_pack
    import fmul32_pkg::*;
(
    input  logic [PROD_W-1:0]       prod,
    input  logic signed [EXP_W+1:0] exp_sum,
    input  logic                    sign,
    output logic [DATA_W-1:0]       result_c
`ifdef FMUL32_BE_FLAGS_EN
    ,
    output flags_t                  flags_c
`endif
);

    // Extra headroom so the +1 normalize and +1 round carry never wrap.
    localparam int unsigned XW = EXP_W + 3;

    logic [FRAC_W-1:0]    mant;
    logic                 guard;
    logic                 sticky;
    logic                 round_up;
    logic [MAN_W-1:0]     mant_inc;
    logic signed [XW-1:0] exp_n;
    logic signed [XW-1:0] exp_r;
    logic                 overflow;
    logic                 underflow;

    // Select the fraction window depending on whether the product is in [2,4).
    always_comb begin
        mant   = prod[PROD_W-3 -: FRAC_W];
        guard  = prod[MAN_W-2];
        sticky = |prod[MAN_W-3:0];
        exp_n  = XW'(exp_sum);
        if (prod[PROD_W-1]) begin
            mant   = prod[PROD_W-2 -: FRAC_W];
            guard  = prod[MAN_W-1];
            sticky = |prod[MAN_W-2:0];
            exp_n  = XW'(exp_sum) + XW'(1);
        end
    end

    // A carry out of the fraction leaves the low bits zero, so only the exponent moves.
    always_comb begin
        round_up  = guard & (sticky | mant[0]);
        mant_inc  = {1'b0, mant} + MAN_W'(round_up);
        exp_r     = mant_inc[MAN_W-1] ? exp_n + XW'(1) : exp_n;
        overflow  = exp_r >= $signed(XW'(EXP_MAX));
        underflow = exp_r <= $signed(XW'(0));
        if (overflow) begin
            result_c = {sign, {EXP_W{1'b1}}, {FRAC_W{1'b0}}};
        end else if (underflow) begin
            result_c = {sign, {(DATA_W-1){1'b0}}};
        end else begin
            result_c = {sign, exp_r[EXP_W-1:0], mant_inc[FRAC_W-1:0]};
        end
    end

`ifdef FMUL32_BE_FLAGS_EN
    always_comb begin
        flags_c.overflow  = overflow;
        flags_c.underflow = underflow;
        flags_c.inexact   = guard | sticky | overflow | underflow;
    end
`endif

endmodule

// File: rtl/fmul32_back_end.sv
// FMUL32 back end: iterative shift-add mantissa multiply, RNE round and pack.
// FMUL32_BE_FLAGS_EN adds the out_flags port.
module fmul32_back_end
    import fmul32_pkg::*;
(
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    in_valid,
    output logic                    in_ready,
    input  logic                    in_sign,
    input  logic                    in_nan,
    input  logic                    in_inf,
    input  logic                    in_zero,
    input  logic signed [EXP_W+1:0] in_exp_sum,
    input  logic [MAN_W-1:0]        in_man_a,
    input  logic [MAN_W-1:0]        in_man_b,
    output logic                    out_valid,
    input  logic                    out_ready,
    output logic [DATA_W-1:0]       result
`ifdef FMUL32_BE_FLAGS_EN
    ,
    output logic [2:0]              out_flags
`endif
);

    state_t                  state_q,     state_d;
    logic [CNT_W-1:0]        cnt_q,       cnt_d;
    logic [PROD_W-1:0]       acc_q,       acc_d;
    logic [MAN_W-1:0]        man_a_q,     man_a_d;
    logic [MAN_W-1:0]        man_b_q,     man_b_d;
    logic signed [EXP_W+1:0] exp_q,       exp_d;
    logic                    sign_q,      sign_d;
    logic [DATA_W-1:0]       result_q,    result_d;
    logic                    out_valid_q, out_valid_d;
    logic                    in_ready_q,  in_ready_d;
    logic [DATA_W-1:0]       norm_result_c;
`ifdef FMUL32_BE_FLAGS_EN
    flags_t                  flags_q,     flags_d;
    flags_t                  norm_flags_c;
`endif

    fmul32_round_pack u_round_pack (
        .prod     (acc_q),
        .exp_sum  (exp_q),
        .sign     (sign_q),
        .result_c (norm_result_c)
`ifdef FMUL32_BE_FLAGS_EN
        ,
        .flags_c  (norm_flags_c)
`endif
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            cnt_q       <= '0;
            acc_q       <= '0;
            man_a_q     <= '0;
            man_b_q     <= '0;
            exp_q       <= '0;
            sign_q      <= 1'b0;
            result_q    <= '0;
            out_valid_q <= 1'b0;
            in_ready_q  <= 1'b1;
`ifdef FMUL32_BE_FLAGS_EN
            flags_q     <= '0;
`endif
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            acc_q       <= acc_d;
            man_a_q     <= man_a_d;
            man_b_q     <= man_b_d;
            exp_q       <= exp_d;
            sign_q      <= sign_d;
            result_q    <= result_d;
            out_valid_q <= out_valid_d;
            in_ready_q  <= in_ready_d;
`ifdef FMUL32_BE_FLAGS_EN
            flags_q     <= flags_d;
`endif
        end
    end

    // Next-state, datapath and registered-output logic.
    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        acc_d       = acc_q;
        man_a_d     = man_a_q;
        man_b_d     = man_b_q;
        exp_d       = exp_q;
        sign_d      = sign_q;
        result_d    = result_q;
        out_valid_d = out_valid_q;
`ifdef FMUL32_BE_FLAGS_EN
        flags_d     = flags_q;
`endif

        case (state_q)
            IDLE: begin
                if (in_valid) begin
                    man_a_d = in_man_a;
                    man_b_d = in_man_b;
                    exp_d   = in_exp_sum;
                    sign_d  = in_sign;
                    acc_d   = '0;
                    cnt_d   = '0;
                    if (in_nan || in_inf || in_zero) begin
                        // Specials bypass the multiplier; priority NaN > INF > ZERO.
                        state_d     = DONE;
                        out_valid_d = 1'b1;
`ifdef FMUL32_BE_FLAGS_EN
                        flags_d     = '0;
`endif
                        if (in_nan) begin
                            result_d = QNAN;
                        end else if (in_inf) begin
                            result_d = {in_sign, {EXP_W{1'b1}}, {FRAC_W{1'b0}}};
                        end else begin
                            result_d = {in_sign, {(DATA_W-1){1'b0}}};
                        end
                    end else begin
                        state_d = MUL;
                    end
                end
            end
            MUL: begin
                if (man_b_q[cnt_q]) begin
                    acc_d = acc_q + (PROD_W'(man_a_q) << cnt_q);
                end
                if (cnt_q == CNT_W'(MAN_W - 1)) begin
                    state_d = NORM;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            NORM: begin
                result_d    = norm_result_c;
                out_valid_d = 1'b1;
                state_d     = DONE;
`ifdef FMUL32_BE_FLAGS_EN
                flags_d     = norm_flags_c;
`endif
            end
            DONE: begin
                if (out_ready) begin
                    out_valid_d = 1'b0;
                    state_d     = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        in_ready_d = (state_d == IDLE);
    end

    assign in_ready  = in_ready_q;
    assign out_valid = out_valid_q;
    assign result    = result_q;
`ifdef FMUL32_BE_FLAGS_EN
    assign out_flags = flags_q;
`endif

endmodule

// File: tb/tb_fmul32_back_end.sv
// Directed self-checking bench for fmul32_back_end with hand-computed results.
module tb_fmul32_back_end;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        in_valid;
    logic        in_ready;
    logic        in_sign;
    logic        in_nan;
    logic        in_inf;
    logic        in_zero;
    logic [9:0]  in_exp_sum;
    logic [23:0] in_man_a;
    logic [23:0] in_man_b;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] result;
`ifdef FMUL32_BE_FLAGS_EN
    logic [2:0]  out_flags;
`endif

    int n_cmp = 0;
    int n_err = 0;
    int edges;
    logic [31:0] held;

    always #5 clk = ~clk;

    fmul32_back_end dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .in_sign    (in_sign),
        .in_nan     (in_nan),
        .in_inf     (in_inf),
        .in_zero    (in_zero),
        .in_exp_sum (in_exp_sum),
        .in_man_a   (in_man_a),
        .in_man_b   (in_man_b),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .result     (result)
`ifdef FMUL32_BE_FLAGS_EN
        ,
        .out_flags  (out_flags)
`endif
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Present one bundle, then count edges (accept edge included) until out_valid.
    task automatic run_op(input logic s, input logic nan, input logic inf, input logic zero,
                          input logic [9:0] e, input logic [23:0] a, input logic [23:0] b,
                          output int n);
        @(negedge clk);
        in_sign    = s;
        in_nan     = nan;
        in_inf     = inf;
        in_zero    = zero;
        in_exp_sum = e;
        in_man_a   = a;
        in_man_b   = b;
        in_valid   = 1'b1;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        n = 1;
        while (!out_valid && n < 60) begin
            @(posedge clk);
            #1;
            n++;
        end
    endtask

    task automatic drain(input string tag);
        @(negedge clk);
        out_ready = 1'b1;
        @(posedge clk);
        #1;
        out_ready = 1'b0;
        check({tag, "_ovalid_drop"}, 32'(out_valid), 32'd0);
        check({tag, "_iready_back"}, 32'(in_ready), 32'd1);
    endtask

    initial begin
        rst_n      = 1'b0;
        in_valid   = 1'b0;
        in_sign    = 1'b0;
        in_nan     = 1'b0;
        in_inf     = 1'b0;
        in_zero    = 1'b0;
        in_exp_sum = '0;
        in_man_a   = '0;
        in_man_b   = '0;
        out_ready  = 1'b0;

        #12;
        check("rst_out_valid", 32'(out_valid), 32'd0);
        check("rst_result", result, 32'h0);
        check("rst_in_ready", 32'(in_ready), 32'd1);
        @(negedge clk);
        rst_n = 1'b1;

        // 1.5 x 2.0 = 3.0
        run_op(1'b0, 1'b0, 1'b0, 1'b0, 10'd128, 24'hC00000, 24'h800000, edges);
        check("mul_latency", 32'(edges), 32'd26);
        check("mul_1p5x2", result, 32'h4040_0000);
        check("mul_in_ready_busy", 32'(in_ready), 32'd0);
        drain("mul_1p5x2");

        // Tie with odd LSB rounds up
        run_op(1'b0, 1'b0, 1'b0, 1'b0, 10'd127, 24'h800001, 24'hC00000, edges);
        check("rne_tie_odd", result, 32'h3FC0_0002);
        drain("rne");

        // Round carries out of the fraction: exponent bumps, fraction zero
        run_op(1'b0, 1'b0, 1'b0, 1'b0, 10'd127, 24'h800001, 24'hFFFFFE, edges);
        check("round_carry", result, 32'h4000_0000);
        drain("carry");

        // Overflow to -inf
        run_op(1'b1, 1'b0, 1'b0, 1'b0, 10'd254, 24'hC00000, 24'hC00000, edges);
        check("overflow", result, 32'hFF80_0000);
`ifdef FMUL32_BE_FLAGS_EN
        check("overflow_flags", 32'(out_flags), 32'h5);
`endif
        drain("ovf");

        // Underflow to -0
        run_op(1'b1, 1'b0, 1'b0, 1'b0, 10'd0, 24'h800000, 24'h800000, edges);
        check("underflow", result, 32'h8000_0000);
`ifdef FMUL32_BE_FLAGS_EN
        check("underflow_flags", 32'(out_flags), 32'h3);
`endif
        drain("udf");

        // 1.0 x 1.0, exact
        run_op(1'b0, 1'b0, 1'b0, 1'b0, 10'd127, 24'h800000, 24'h800000, edges);
        check("one_x_one", result, 32'h3F80_0000);
`ifdef FMUL32_BE_FLAGS_EN
        check("exact_flags", 32'(out_flags), 32'h0);
`endif
        drain("one");

        // Exponent boundaries: smallest and largest normal exponents
        run_op(1'b0, 1'b0, 1'b0, 1'b0, 10'd1, 24'h800000, 24'h800000, edges);
        check("exp_min_normal", result, 32'h0080_0000);
        drain("emin");
        run_op(1'b0, 1'b0, 1'b0, 1'b0, 10'd254, 24'h800000, 24'h800000, edges);
        check("exp_max_normal", result, 32'h7F00_0000);
        drain("emax");

        // Specials: NaN wins over INF, one edge latency, sign ignored
        run_op(1'b1, 1'b1, 1'b1, 1'b0, 10'd5, 24'h800000, 24'h800000, edges);
        check("nan_latency", 32'(edges), 32'd1);
        check("nan_over_inf", result, 32'h7FC0_0000);
`ifdef FMUL32_BE_FLAGS_EN
        check("special_flags", 32'(out_flags), 32'h0);
`endif
        drain("nan");
        run_op(1'b1, 1'b0, 1'b1, 1'b1, 10'd5, 24'h800000, 24'h800000, edges);
        check("inf_over_zero", result, 32'hFF80_0000);
        drain("inf");
        run_op(1'b1, 1'b0, 1'b0, 1'b1, 10'd200, 24'hC00000, 24'hC00000, edges);
        check("zero_special", result, 32'h8000_0000);
        drain("zero");

        // Back-pressure: result holds, new bundle (a NaN) is ignored
        run_op(1'b0, 1'b0, 1'b0, 1'b0, 10'd128, 24'hC00000, 24'h800000, edges);
        held = result;
        check("bp_first", held, 32'h4040_0000);
        @(negedge clk);
        in_nan   = 1'b1;
        in_valid = 1'b1;
        for (int i = 0; i < 5; i++) begin
            @(posedge clk);
            #1;
            check("bp_result_stable", result, 32'h4040_0000);
            check("bp_out_valid", 32'(out_valid), 32'd1);
            check("bp_in_ready", 32'(in_ready), 32'd0);
        end
        @(negedge clk);
        in_valid = 1'b0;
        in_nan   = 1'b0;
        drain("bp");
        @(posedge clk);
        #1;
        check("bp_ignored_result", result, 32'h4040_0000);
        check("bp_no_spurious_valid", 32'(out_valid), 32'd0);

        // Reset in the middle of the multiply
        @(negedge clk);
        in_sign    = 1'b0;
        in_exp_sum = 10'd127;
        in_man_a   = 24'h800001;
        in_man_b   = 24'hC00000;
        in_valid   = 1'b1;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        repeat (10) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        check("rst_mid_out_valid", 32'(out_valid), 32'd0);
        check("rst_mid_result", result, 32'h0);
        check("rst_mid_in_ready", 32'(in_ready), 32'd1);
        @(negedge clk);
        rst_n = 1'b1;
        repeat (30) @(posedge clk);
        #1;
        check("rst_mid_no_emit", 32'(out_valid), 32'd0);

        run_op(1'b0, 1'b0, 1'b0, 1'b0, 10'd127, 24'h800001, 24'hC00000, edges);
        check("post_rst_latency", 32'(edges), 32'd26);
        check("post_rst_result", result, 32'h3FC0_0002);
        drain("post");

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/fmul32_back_end.md
Name: fmul32_back_end

Overview:
- Consumer end of the FMUL32 first pipeline stage.
- Accepts the pre-decoded product bundle over a valid/ready handshake:
  - resolved sign
  - special-case flags
  - biased exponent sum
  - two 24-bit mantissas with hidden bit
- Multiplies the mantissas with an iterative radix-2 shift-add engine, then normalizes, rounds to nearest-even, packs an IEEE-754 single and presents it with `out_valid`.
- Subnormal inputs arrive as `in_zero`; subnormal results flush to signed zero.

Parameters:
- DATA_W, 32: packed result width.
- EXP_W, 8: exponent field width.
- MAN_W, 24: mantissa width including hidden bit; also the multiply iteration count.

Ports:
- clk  in  1  clock.
- rst_n  in  1  asynchronous active-low reset.
- in_valid  in  1  input bundle valid.
- in_ready  out  1  block can accept a bundle.
- in_sign  in  1  resolved result sign.
- in_nan  in  1  result is NaN.
- in_inf  in  1  result is infinity.
- in_zero  in  1  result is zero.
- in_exp_sum  in  EXP_W+2  signed biased exponent: expA+expB-127, two's complement.
- in_man_a  in  MAN_W  mantissa A, hidden bit at MSB.
- in_man_b  in  MAN_W  mantissa B, hidden bit at MSB.
- out_valid  out  1  result valid; held until accepted.
- out_ready  in  1  downstream accepts the result.
- result  out  DATA_W  packed IEEE-754 single.

Behaviour:
- Reset (asynchronous, active-low):
  - Outputs: `out_valid`=0, `result`=0, `in_ready`=1.
  - Internal state: state=IDLE, counter=0, product accumulator cleared.
  - Reset mid-operation aborts the operation; no result is emitted.
- FSM states: IDLE, MUL, NORM, DONE.
- IDLE:
  - `in_ready`=1.
  - On `in_valid`: capture all inputs.
  - If any of nan/inf/zero is set, go to DONE with the special result. Otherwise go to MUL with counter=0.
- MUL, one multiplier bit per cycle, LSB first:
  - If `man_b[cnt]`=1, `acc += man_a << cnt`, into a 2*MAN_W-bit accumulator.
  - Leave MUL after MAN_W cycles, when cnt=MAN_W-1.
- NORM (single cycle) → DONE, with `out_valid`=1 and `result` registered:
  - If P[47]=1: mant=P[46:24], guard=P[23], sticky=|P[22:0], exp=exp_sum+1.
  - Else: mant=P[45:23], guard=P[22], sticky=|P[21:0], exp=exp_sum.
  - Rounding (RNE): round up if guard & (sticky | mant[0]).
  - Mantissa carry-out on rounding → mant=0, exp+1.
  - exp ≥ 255 → {sign, 8'hFF, 23'h0}.
  - exp ≤ 0 → {sign, 31'h0}.
  - Otherwise {sign, exp[7:0], mant}.
- Special results:
  - Priority NaN > INF > ZERO.
  - NaN = 32'h7FC00000 (canonical, sign ignored).
  - INF = {sign, 8'hFF, 23'h0}.
  - ZERO = {sign, 31'h0}.
- DONE:
  - `out_valid`=1; `result` stable until accepted.
  - On `out_ready` → IDLE; `out_valid` drops next cycle.
- Latency from the accept edge:
  - Normal operands: MAN_W+2 edges to `out_valid` (26 for defaults).
  - Special operands: 1 edge.
- Handshake rules:
  - `in_ready`=0 in MUL/NORM/DONE; `in_valid` is ignored there and inputs are not sampled.
  - No accept in the same cycle as `out_ready` in DONE; a one-cycle bubble is mandatory.
  - `out_valid` never deasserts without `out_ready`.

Optional Feature:
- Macro: FMUL32_BE_FLAGS_EN.
- Defined:
  - Adds output port `out_flags[2:0]` = {overflow, underflow, inexact}, valid with `out_valid`.
  - overflow: set when exp ≥ 255 after rounding.
  - underflow: set when exp ≤ 0 on a non-special operand.
  - inexact: guard|sticky, or overflow, or underflow.
  - All flags are 0 for special results.
  - Reset value 0.
- Undefined: the port and its logic are absent; `result` behaviour is identical.

Decomposition:
- Shared package `fmul32_pkg`:
  - Constants: EXP_BIAS=127, EXP_MAX=255, QNAN=32'h7FC00000, MAN_W, EXP_W.
  - FSM state typedef: IDLE/MUL/NORM/DONE.
  - Flag-vector typedef.
- One sub-module: `fmul32_round_pack`.
  - Purely combinational: 48-bit product + exp + sign → packed result (+ flags).
  - Instantiated by the NORM stage.
- Shift-add engine and FSM stay in the top module.

Test Plan:
- 1.5×2.0: sign=0, exp_sum=128, man_a=0xC00000, man_b=0x800000 → `result`=0x40400000, `out_valid` exactly 26 cycles after accept.
- RNE tie, odd LSB: exp_sum=127, man_a=0x800001, man_b=0xC00000 → 0x3FC00002 (rounded up from 0x3FC00001).
- Overflow: sign=1, exp_sum=254, man_a=man_b=0xC00000 → 0xFF800000; overflow flag=1 when FMUL32_BE_FLAGS_EN is defined.
- Underflow and special cases:
  - sign=1, exp_sum=0, man_a=man_b=0x800000 → 0x80000000.
  - in_nan=1 with in_inf=1 → 0x7FC00000, one cycle after accept.
- Back-pressure: hold `out_ready`=0 for 5 cycles after `out_valid` → `result` stable, `in_ready`=0, new `in_valid` ignored. Then `out_ready`=1 → `out_valid`=0 and `in_ready`=1 next cycle.
- Reset mid-MUL: deassert `rst_n` at iteration 10 → `out_valid`=0, `result`=0, `in_ready`=1 immediately. Next operation completes correctly.
